// File: rtl/disp_pkg.sv
// Shared types and constants for the display arbiter and its round-robin picker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package disp_pkg;

   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int IW   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      CHECK = 2'd2
   } state_t;

   // One-hot mask for a requester index.
   function automatic logic [NREQ-1:0] idx2mask(input logic [IW-1:0] idx);
      logic [NREQ-1:0] m;
      m      = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// Round-robin picker: first set request after ptr (wrapping), skipping excluded lines.
// Latency: purely combinational.
// Backpressure: none; vld low when no eligible request exists.
module disp_rr_pick
   import disp_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   input  logic [NREQ-1:0] excl,
   output logic [IW-1:0]   win,
   output logic            vld
);

   logic [NREQ-1:0] cand;
   logic [IW-1:0]   idx;

   // Scan ptr+1, ptr+2, ... ptr+NREQ (the last one is ptr itself) and keep the first hit.
   always_comb begin
      cand = req & ~excl;
      win  = '0;
      vld  = 1'b0;
      idx  = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = ptr + IW'(i);
         if (!vld && cand[idx]) begin
            win = idx;
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner of the 8-digit display; an owner keeps it HOLD_CYC cycles (HOLD plus the CHECK cycle).
// Latency: grant one edge after req is sampled (second edge after reset release); dato one edge after data_in.
// Backpressure: none; requests are level-sensitive and only re-evaluated in CHECK, never pre-empting an owner.
module disp_arbiter
   import disp_pkg::*;
#(
   parameter logic [31:0] HOLD_CYC = 32'd50_000_000,
   parameter logic [31:0] IDLE_VAL = 32'h0000_0000
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*DW-1:0]  data_in,
   output logic [NREQ-1:0]     gnt,
   output logic [IW-1:0]       owner,
   output logic                busy,
   output logic [DW-1:0]       dato
);

   state_t          state;
   logic [31:0]     hold_cnt;
   logic [IW-1:0]   ptr;
   logic            armed;      // low for the first edge after reset so no grant lands on it
   logic [NREQ-1:0] excl;
   logic [IW-1:0]   pick_win;
   logic            pick_vld;
   logic [DW-1:0]   own_dat;

   // Outside CHECK nobody is excluded; in CHECK the current owner is skipped so others get a turn.
   always_comb begin
      excl = '0;
      if (state == CHECK) begin
         excl = idx2mask(owner);
      end
   end

   // Select the current owner's 32-bit slice of data_in.
   always_comb begin
      own_dat = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner == IW'(i)) begin
            own_dat = data_in[i*DW +: DW];
         end
      end
   end

   disp_rr_pick u_pick (
      .req  (req),
      .ptr  (ptr),
      .excl (excl),
      .win  (pick_win),
      .vld  (pick_vld)
   );

   // Arbitration FSM with hold counter, round-robin pointer and registered display word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         busy     <= 1'b0;
         owner    <= '0;
         dato     <= IDLE_VAL;
         hold_cnt <= '0;
         ptr      <= IW'(NREQ - 1);
         armed    <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               dato <= IDLE_VAL;
               if (armed && pick_vld) begin
                  state    <= HOLD;
                  gnt      <= idx2mask(pick_win);
                  owner    <= pick_win;
                  ptr      <= pick_win;
                  busy     <= 1'b1;
                  hold_cnt <= HOLD_CYC - 32'd1;
               end
            end
            HOLD: begin
               // A dropped request freezes the display word; the grant still runs its full time.
               if (req[owner]) begin
                  dato <= own_dat;
               end
               if (hold_cnt != 32'd0) begin
                  hold_cnt <= hold_cnt - 32'd1;
               end
               // Counter reaches zero as we enter CHECK, which is the last cycle of the tenure.
               if (hold_cnt <= 32'd1) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (req[owner]) begin
                  dato <= own_dat;
               end
               if (pick_vld) begin
                  state    <= HOLD;
                  gnt      <= idx2mask(pick_win);
                  owner    <= pick_win;
                  ptr      <= pick_win;
                  hold_cnt <= HOLD_CYC - 32'd1;
               end else if (req[owner]) begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_CYC - 32'd1;
               end else begin
                  state <= IDLE;
                  gnt   <= '0;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
